// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
// Imported by the scoreboard and the register file top.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_word_t;
  typedef logic [ADDR_W:0]   reg_cnt_t;
  typedef logic [NUM_REGS-1:0] busy_vec_t;

  localparam reg_idx_t XZR = reg_idx_t'(ZERO_REG);

  function automatic logic is_xzr(
    input reg_idx_t idx
  );
    return idx == XZR;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Write-pending scoreboard: one busy bit per register plus
// an incrementally tracked count of set bits.
module reg_file_scoreboard
  import regfile_pkg::*;
(
  input  logic      CLK,
  input  logic      RST_N,
  input  logic      WR_EN,
  input  reg_idx_t  WR_ADDR,
  input  logic      ISSUE_EN,
  input  reg_idx_t  ISSUE_ADDR,
  input  logic      FLUSH,
  output busy_vec_t BUSY,
  output reg_cnt_t  PENDING
);

  busy_vec_t busy_q;
  busy_vec_t busy_d;
  reg_cnt_t  pend_q;
  logic      clr;
  logic      set;
  logic      inc;
  logic      dec;

  assign clr = WR_EN && !is_xzr(WR_ADDR);
  assign set = ISSUE_EN && !is_xzr(ISSUE_ADDR);

  // A set on the same index as the clear wins: newer producer.
  always_comb begin
    busy_d = busy_q;
    inc    = 1'b0;
    dec    = 1'b0;
    if (clr) begin
      busy_d[WR_ADDR] = 1'b0;
    end
    if (set) begin
      busy_d[ISSUE_ADDR] = 1'b1;
    end
    inc = set && !busy_q[ISSUE_ADDR];
    dec = clr && busy_q[WR_ADDR]
       && !(set && (ISSUE_ADDR == WR_ADDR));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      busy_q <= '0;
      pend_q <= '0;
    end else if (FLUSH) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_q
              + {{ADDR_W{1'b0}}, inc}
              - {{ADDR_W{1'b0}}, dec};
    end
  end

  assign BUSY    = busy_q;
  assign PENDING = pend_q;

endmodule

// File: rtl/reg_file_sb.sv
// 32x64 register file with write-pending scoreboard, XZR = X31.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_sb
  import regfile_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] RD_ADDR_A,
  input  logic [ADDR_W-1:0] RD_ADDR_B,
  output logic [DATA_W-1:0] RD_DATA_A,
  output logic [DATA_W-1:0] RD_DATA_B,
  output logic              BUSY_A,
  output logic              BUSY_B,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              ISSUE_EN,
  input  logic [ADDR_W-1:0] ISSUE_ADDR,
  input  logic              FLUSH,
  output logic [ADDR_W:0]   PENDING
);

  reg_word_t mem [NUM_REGS];
  busy_vec_t busy;
  logic      wr_ok;

  assign wr_ok = WR_EN && !is_xzr(WR_ADDR);

  // Entry 31 is never written; reads of it are masked to zero.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

  reg_file_scoreboard u_sb (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .ISSUE_EN   (ISSUE_EN),
    .ISSUE_ADDR (ISSUE_ADDR),
    .FLUSH      (FLUSH),
    .BUSY       (busy),
    .PENDING    (PENDING)
  );

`ifdef REGFILE_BYPASS_EN
  logic hit_a;
  logic hit_b;
  logic iss_a;
  logic iss_b;

  assign hit_a = wr_ok && (WR_ADDR == RD_ADDR_A);
  assign hit_b = wr_ok && (WR_ADDR == RD_ADDR_B);
  assign iss_a = ISSUE_EN && !FLUSH
              && (ISSUE_ADDR == RD_ADDR_A);
  assign iss_b = ISSUE_EN && !FLUSH
              && (ISSUE_ADDR == RD_ADDR_B);

  always_comb begin
    RD_DATA_A = '0;
    BUSY_A    = 1'b0;
    if (!is_xzr(RD_ADDR_A)) begin
      RD_DATA_A = hit_a ? WR_DATA : mem[RD_ADDR_A];
      BUSY_A    = (hit_a && !iss_a) ? 1'b0
                                    : busy[RD_ADDR_A];
    end
  end

  always_comb begin
    RD_DATA_B = '0;
    BUSY_B    = 1'b0;
    if (!is_xzr(RD_ADDR_B)) begin
      RD_DATA_B = hit_b ? WR_DATA : mem[RD_ADDR_B];
      BUSY_B    = (hit_b && !iss_b) ? 1'b0
                                    : busy[RD_ADDR_B];
    end
  end
`else
  always_comb begin
    RD_DATA_A = '0;
    BUSY_A    = 1'b0;
    if (!is_xzr(RD_ADDR_A)) begin
      RD_DATA_A = mem[RD_ADDR_A];
      BUSY_A    = busy[RD_ADDR_A];
    end
  end

  always_comb begin
    RD_DATA_B = '0;
    BUSY_B    = 1'b0;
    if (!is_xzr(RD_ADDR_B)) begin
      RD_DATA_B = mem[RD_ADDR_B];
      BUSY_B    = busy[RD_ADDR_B];
    end
  end
`endif

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 32 x 64-bit integer register file for the 5-stage pipeline, with a write-pending scoreboard.
- Decode reads two source operands. Writeback writes one destination.
- Decode marks a destination busy at issue. Writeback clears it.
- BUSY flags feed the hazard/stall unit. X31 is hard-wired zero (XZR).

Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, register index width
- ZERO_REG, 31, index that always reads 0; writes to it and issues to it are ignored

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  synchronous active-low reset
- RD_ADDR_A  in  ADDR_W  read port A index
- RD_ADDR_B  in  ADDR_W  read port B index
- RD_DATA_A  out  DATA_W  read port A data
- RD_DATA_B  out  DATA_W  read port B data
- BUSY_A  out  1  register at RD_ADDR_A has a pending write
- BUSY_B  out  1  register at RD_ADDR_B has a pending write
- WR_EN  in  1  writeback strobe
- WR_ADDR  in  ADDR_W  writeback destination
- WR_DATA  in  DATA_W  writeback data
- ISSUE_EN  in  1  decode issues an instruction with a destination
- ISSUE_ADDR  in  ADDR_W  destination being issued
- FLUSH  in  1  clear all busy bits (pipeline squash)
- PENDING  out  ADDR_W+1  number of set busy bits

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous, active-low on RST_N, sampled at posedge CLK.
- Reset state: all 31 data registers = 0, all busy bits = 0, PENDING = 0. RST_N overrides WR_EN, ISSUE_EN and FLUSH in the same cycle.
- Reads are combinational:
  - RD_DATA_x = array[RD_ADDR_x], or 0 when RD_ADDR_x == ZERO_REG.
  - BUSY_x = busy[RD_ADDR_x], or 0 for ZERO_REG.
  - Outputs are defined during reset and reflect the cleared array after the reset edge.
- Write: at posedge, if WR_EN && WR_ADDR != ZERO_REG, array[WR_ADDR] <= WR_DATA. A new value is visible on the read ports the cycle after the edge (see Optional Feature).
- Scoreboard update at posedge, in priority order:
  1. FLUSH=1: all busy bits <= 0, PENDING <= 0. ISSUE_EN is ignored that cycle. WR_EN still writes the data array.
  2. Otherwise, WR_EN with a non-zero address clears busy[WR_ADDR].
  3. ISSUE_EN with a non-zero address sets busy[ISSUE_ADDR].
- Same address issued and written in the same cycle: the set wins, so the bit ends 1 (a newer producer is in flight). Data is still written.
- Issue to an already-busy register: the bit stays 1 and PENDING is unchanged. One busy bit per register; the pipeline guarantees writeback order.
- Writeback to a non-busy register: the data is written, the bit stays 0 and PENDING is unchanged.
- PENDING update, tracked incrementally:
  - +1 if a bit goes 0->1.
  - -1 if a different bit goes 1->0.
  - Net 0 when both occur, or for a same-address set-wins on an already-busy bit.
  - Saturation is impossible: maximum is 31.
- The busy-bit transition rules above define PENDING exactly.
- Invariant: PENDING equals the popcount of the busy bits at every cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - If WR_EN && WR_ADDR == RD_ADDR_x && WR_ADDR != ZERO_REG, then RD_DATA_x = WR_DATA combinationally in the same cycle.
  - BUSY_x is forced to 0 in that cycle, unless ISSUE_EN targets the same address in the same cycle with FLUSH=0; then BUSY_x shows the stored bit.
  - This provides write-then-read in one cycle.
- Undefined:
  - RD_DATA_x returns the old array value during the write cycle; BUSY_x shows the stored bit.
  - The decode stage stalls one extra cycle.

Decomposition:
- Shared package (regfile_pkg):
  - constants DATA_W, ADDR_W, ZERO_REG, NUM_REGS = 32
  - typedef reg_idx_t for a register index, typedef reg_word_t for a register word
- Sub-module reg_file_scoreboard:
  - contains the busy bit vector, set/clear/flush priority logic and the PENDING counter
  - inputs: CLK, RST_N, WR_EN/WR_ADDR, ISSUE_EN/ISSUE_ADDR, FLUSH
  - outputs: busy vector, PENDING
- The top level holds the data array, zero-register masking and bypass muxes.

Test Plan:
- Reset: RST_N=0 for 1 cycle while writing X5=0xDEAD -> after the edge, reading X5 gives 0, BUSY_A=0, PENDING=0.
- Write/read: WR_EN, X3=0x0123456789ABCDEF; next cycle RD_ADDR_A=3 -> 0x0123456789ABCDEF. Write X31=0xFFFF then read X31 -> 0. Issue to X31 -> PENDING stays 0.
- Scoreboard: issue X7, then X9 -> PENDING=2, BUSY on reads of 7 and 9. WR X7 -> BUSY(7)=0, PENDING=1. Issue X9 again -> PENDING stays 1.
- Same-cycle issue and write: X4 busy; issue X4 and WR X4=0x55 together -> busy(4) stays 1, X4 reads 0x55, PENDING unchanged.
- FLUSH: X1, X2, X6 busy; FLUSH with ISSUE X8 and WR X2=0x77 -> PENDING=0, no busy bits, X8 not busy, X2 reads 0x77.
- Bypass (REGFILE_BYPASS_EN): RD_ADDR_B=10, WR X10=0xAA same cycle -> RD_DATA_B=0xAA and BUSY_B=0 that cycle. Without the macro -> old value, stored busy bit.
